// File: rtl/spi_reg_pkg.sv
// Shared types and helpers for the SPI register bank.
//   state_t  : frame decoder states
//   RW_WRITE : value of the leading frame bit for a write
//   RW_READ  : value of the leading frame bit for a read
//   frame_w  : total frame width (R/W bit + address + data)
package spi_reg_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    DONE
  } state_t;

  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

  function automatic int frame_w(input int addr_w, input int data_w);
    return 1 + addr_w + data_w;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser followed by an edge-detect flop.
// Ports:
//   clk, rst : system clock, synchronous active-high reset
//   d        : asynchronous input(s)
//   level    : synchronised level
//   rise     : one-cycle pulse on a synchronised 0->1 transition
//   fall     : one-cycle pulse on a synchronised 1->0 transition
// RST_VAL sets the idle level of all stages so that no edge is seen
// on reset release while the input sits at its idle level.
module spi_sync_edge #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] prev_q;

  // NOTE: every flop is written with <= so all stages sample the values
  // from before the edge; blocking assignments would collapse the chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
      prev_q <= RST_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign level = sync_q;
  assign rise  = sync_q & ~prev_q;
  assign fall  = ~sync_q & prev_q;

endmodule

// File: rtl/spi_reg_bank.sv
// SPI Mode 0 peripheral driving a NUM_REGS x DATA_W register bank.
// Frame: 1 R/W bit, ADDR_W address bits, DATA_W data bits, MSB first.
// Ports:
//   clk, rst  : system clock, synchronous active-high reset
//   sclk      : SPI clock (asynchronous)
//   copi      : SPI data in (asynchronous)
//   ncs       : SPI chip select, active low (asynchronous)
//   cipo      : SPI data out (read data during the data phase)
//   regs_out  : packed bank, register i at [i*DATA_W +: DATA_W]
//   wr_valid  : one-cycle pulse on each committed write frame
//   wr_addr   : address of the last committed write
//   wr_data   : data of the last committed write
// Build option: define SPI_REG_READ_EN to enable read-back on cipo;
// otherwise cipo is tied low and read frames have no effect.
// SCLK high and low phases must each last at least 4 clk periods.
module spi_reg_bank
  import spi_reg_pkg::*;
#(
  parameter int                ADDR_W    = 7,
  parameter int                DATA_W    = 8,
  parameter int                NUM_REGS  = 5,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sclk,
  input  logic                       copi,
  input  logic                       ncs,
  output logic                       cipo,
  output logic [NUM_REGS*DATA_W-1:0] regs_out,
  output logic                       wr_valid,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic [DATA_W-1:0]          wr_data
);

  localparam int FRAME_W = frame_w(ADDR_W, DATA_W);
  localparam int CNT_W   = $clog2(FRAME_W + 1);

  logic sclk_lvl_unused, sclk_rise, sclk_fall;
  logic ncs_lvl, ncs_rise_unused, ncs_fall;
  logic copi_lvl, copi_rise_unused, copi_fall_unused;

  spi_sync_edge #(.WIDTH(1), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst(rst), .d(sclk),
    .level(sclk_lvl_unused), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.WIDTH(1), .RST_VAL(1'b1)) u_sync_ncs (
    .clk(clk), .rst(rst), .d(ncs),
    .level(ncs_lvl), .rise(ncs_rise_unused), .fall(ncs_fall)
  );

  spi_sync_edge #(.WIDTH(1), .RST_VAL(1'b0)) u_sync_copi (
    .clk(clk), .rst(rst), .d(copi),
    .level(copi_lvl), .rise(copi_rise_unused), .fall(copi_fall_unused)
  );

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q;
  logic [FRAME_W-1:0]   sh_q;
  logic [FRAME_W-1:0]   sh_next;
  logic                 rw_q;
  logic [ADDR_W-1:0]    addr_q;
  logic                 shift_en, hdr_done, last_bit;

  assign sh_next  = {sh_q[FRAME_W-2:0], copi_lvl};
  assign shift_en = !ncs_lvl && sclk_rise && (state_q == ADDR || state_q == DATA);
  assign hdr_done = shift_en && state_q == ADDR && cnt_q == CNT_W'(ADDR_W);
  assign last_bit = shift_en && state_q == DATA && cnt_q == CNT_W'(FRAME_W - 1);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: state_d gets its default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    if (ncs_lvl) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (ncs_fall) state_d = ADDR;
        ADDR:    if (hdr_done) state_d = DATA;
        DATA:    if (last_bit) state_d = DONE;
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: the register bank is reset like the rest of the state because
  // downstream PWM/enable logic consumes it directly out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      sh_q     <= '0;
      rw_q     <= RW_READ;
      addr_q   <= '0;
      wr_valid <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      regs_out <= {NUM_REGS{RESET_VAL}};
    end else begin
      wr_valid <= 1'b0;
      // A frame start, or chip select deasserting (including an abort),
      // discards any partially received bits. A coincident sclk_rise at
      // frame start is dropped here because IDLE does not shift.
      if (ncs_lvl || (state_q == IDLE && ncs_fall)) begin
        cnt_q <= '0;
        sh_q  <= '0;
      end else if (shift_en) begin
        sh_q  <= sh_next;
        cnt_q <= cnt_q + 1'b1;
        if (hdr_done) begin
          rw_q   <= sh_next[ADDR_W];
          addr_q <= sh_next[ADDR_W-1:0];
        end
        if (last_bit && rw_q == RW_WRITE) begin
          wr_valid <= 1'b1;
          wr_addr  <= addr_q;
          wr_data  <= sh_next[DATA_W-1:0];
          // Out-of-range addresses match no index and leave the bank alone.
          for (int i = 0; i < NUM_REGS; i++) begin
            if (addr_q == ADDR_W'(i)) regs_out[i*DATA_W +: DATA_W] <= sh_next[DATA_W-1:0];
          end
        end
      end
    end
  end

`ifdef SPI_REG_READ_EN
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] rd_sh_q;
  logic              rd_loaded_q;

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (addr_q == ADDR_W'(i)) rd_word = regs_out[i*DATA_W +: DATA_W];
    end
  end

  // The first sclk_fall of the data phase loads the addressed register;
  // each later fall presents the next bit on the MSB.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_sh_q     <= '0;
      rd_loaded_q <= 1'b0;
    end else if (ncs_lvl || hdr_done) begin
      rd_sh_q     <= '0;
      rd_loaded_q <= 1'b0;
    end else if (state_q == DATA && rw_q == RW_READ && sclk_fall) begin
      if (!rd_loaded_q) begin
        rd_sh_q     <= rd_word;
        rd_loaded_q <= 1'b1;
      end else begin
        rd_sh_q <= {rd_sh_q[DATA_W-2:0], 1'b0};
      end
    end
  end

  assign cipo = (state_q == DATA && !ncs_lvl) ? rd_sh_q[DATA_W-1] : 1'b0;
`else
  logic unused_sclk_fall;
  assign unused_sclk_fall = sclk_fall;
  assign cipo             = 1'b0;
`endif

endmodule

// File: tb/tb_spi_reg_bank.sv
// Scoreboard bench for spi_reg_bank: stimulus pushes expected writes and
// expected read-back bits into queues; monitors pop and compare when the
// DUT presents wr_valid or when the master samples cipo.
module tb_spi_reg_bank;

  localparam int HALF = 8;  // SPI half period in clk cycles

  typedef struct {
    logic [6:0]  addr;
    logic [7:0]  data;
    logic [39:0] bank;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // Default configuration DUT
  logic        sclk_a = 1'b0, copi_a = 1'b0, ncs_a = 1'b1;
  logic        cipo_a;
  logic [39:0] regs_a;
  logic        wr_valid_a;
  logic [6:0]  wr_addr_a;
  logic [7:0]  wr_data_a;

  // Wide configuration DUT: ADDR_W=4, DATA_W=16, NUM_REGS=16
  logic         sclk_b = 1'b0, copi_b = 1'b0, ncs_b = 1'b1;
  logic         cipo_b;
  logic [255:0] regs_b;
  logic         wr_valid_b;
  logic [3:0]   wr_addr_b;
  logic [15:0]  wr_data_b;

  int   n_vec = 0;
  int   n_err = 0;
  int   n_pulse_b = 0;
  bit   rd_window = 1'b0;
  exp_t sb_q[$];
  logic cipo_q[$];
  logic [39:0] model;
  exp_t mon_e;
  logic mon_bit;

  always #5 clk = ~clk;

  spi_reg_bank u_dut_a (
    .clk(clk), .rst(rst), .sclk(sclk_a), .copi(copi_a), .ncs(ncs_a),
    .cipo(cipo_a), .regs_out(regs_a), .wr_valid(wr_valid_a),
    .wr_addr(wr_addr_a), .wr_data(wr_data_a)
  );

  spi_reg_bank #(.ADDR_W(4), .DATA_W(16), .NUM_REGS(16)) u_dut_b (
    .clk(clk), .rst(rst), .sclk(sclk_b), .copi(copi_b), .ncs(ncs_b),
    .cipo(cipo_b), .regs_out(regs_b), .wr_valid(wr_valid_b),
    .wr_addr(wr_addr_b), .wr_data(wr_data_b)
  );

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input bit sel, input logic s, input logic c, input logic n);
    if (sel) begin sclk_b = s; copi_b = c; ncs_b = n; end
    else     begin sclk_a = s; copi_a = c; ncs_a = n; end
  endtask

  // Sends nbits bits of a left-aligned vector. Read frames on DUT A open
  // the cipo sampling window for data bits 8..15.
  task automatic spi_frame(input bit sel, input logic [31:0] bits, input int nbits,
                           input bit is_read, input bit leave_cs);
    logic b;
    drive(sel, 1'b0, 1'b0, 1'b0);
    wait_clks(HALF);
    for (int i = 0; i < nbits; i++) begin
      b = bits[31-i];
      drive(sel, 1'b0, b, 1'b0);
      wait_clks(HALF);
      rd_window = !sel && is_read && i >= 8 && i < 16;
      drive(sel, 1'b1, b, 1'b0);
      wait_clks(HALF);
      rd_window = 1'b0;
      drive(sel, 1'b0, b, 1'b0);
    end
    if (!leave_cs) begin
      wait_clks(HALF);
      drive(sel, 1'b0, 1'b0, 1'b1);
      wait_clks(2 * HALF);
    end
  endtask

  task automatic push_write(input logic [6:0] a, input logic [7:0] d);
    exp_t e;
    if (a < 7'd5) model[a*8 +: 8] = d;
    e.addr = a;
    e.data = d;
    e.bank = model;
    sb_q.push_back(e);
  endtask

  task automatic push_read(input logic [7:0] d);
    for (int i = 7; i >= 0; i--) begin
`ifdef SPI_REG_READ_EN
      cipo_q.push_back(d[i]);
`else
      cipo_q.push_back(1'b0);
`endif
    end
  endtask

  // Write monitor for DUT A
  always @(negedge clk) begin
    if (wr_valid_a) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_wr_valid: got addr %0h data %0h, expected no write",
                 wr_addr_a, wr_data_a);
      end else begin
        mon_e = sb_q.pop_front();
        check("wr_addr", 256'(wr_addr_a), 256'(mon_e.addr));
        check("wr_data", 256'(wr_data_a), 256'(mon_e.data));
        check("regs_out_at_commit", 256'(regs_a), 256'(mon_e.bank));
      end
    end
    if (wr_valid_b) n_pulse_b++;
  end

  // Read-back monitor: sampled on the master's rising edge
  always @(posedge sclk_a) begin
    if (rd_window) begin
      if (cipo_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL cipo_unexpected: got %b expected no sample", cipo_a);
      end else begin
        mon_bit = cipo_q.pop_front();
        check("cipo_bit", 256'(cipo_a), 256'(mon_bit));
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model = '0;
    wait_clks(4);
    check("reset_regs", 256'(regs_a), 256'(0));
    check("reset_wr_valid", 256'(wr_valid_a), 256'(0));
    check("reset_wr_addr", 256'(wr_addr_a), 256'(0));
    check("reset_wr_data", 256'(wr_data_a), 256'(0));
    check("reset_cipo", 256'(cipo_a), 256'(0));
    rst = 1'b0;
    wait_clks(4);

    // 1: write 0xF0 to address 0
    push_write(7'h00, 8'hF0);
    spi_frame(1'b0, {16'h80F0, 16'h0}, 16, 1'b0, 1'b0);
    check("t1_reg0", 256'(regs_a[7:0]), 256'(8'hF0));

    // 2: write 0xA5 to address 3, then read it back
    push_write(7'h03, 8'hA5);
    spi_frame(1'b0, {16'h83A5, 16'h0}, 16, 1'b0, 1'b0);
    push_read(8'hA5);
    spi_frame(1'b0, {16'h0300, 16'h0}, 16, 1'b1, 1'b0);
    check("t2_regs_after_read", 256'(regs_a), 256'(model));

    // 3: out-of-range write and read
    push_write(7'h7F, 8'h99);
    spi_frame(1'b0, {16'hFF99, 16'h0}, 16, 1'b0, 1'b0);
    check("t3_regs_unchanged", 256'(regs_a), 256'(40'h00_A5_00_00_F0));
    push_read(8'h00);
    spi_frame(1'b0, {16'h7F00, 16'h0}, 16, 1'b1, 1'b0);

    // 4: aborted write after 10 bits, then a full one
    spi_frame(1'b0, {16'h8155, 16'h0}, 10, 1'b0, 1'b0);
    check("t4_reg1_after_abort", 256'(regs_a[15:8]), 256'(8'h00));
    push_write(7'h01, 8'h55);
    spi_frame(1'b0, {16'h8155, 16'h0}, 16, 1'b0, 1'b0);
    check("t4_reg1_after_full", 256'(regs_a[15:8]), 256'(8'h55));

    // 5: 20 clocks in one frame, only the first 16 bits count
    push_write(7'h02, 8'h3C);
    spi_frame(1'b0, {16'h823C, 4'hF, 12'h0}, 20, 1'b0, 1'b0);
    check("t5_reg2", 256'(regs_a[23:16]), 256'(8'h3C));

    // 6: reset during a write frame
    spi_frame(1'b0, {16'h84FF, 16'h0}, 12, 1'b0, 1'b1);
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    wait_clks(3);
    rst = 1'b0;
    model = '0;
    wait_clks(2 * HALF);
    check("t6_regs_reset", 256'(regs_a), 256'(0));
    check("t6_wr_addr_reset", 256'(wr_addr_a), 256'(0));
    check("t6_wr_data_reset", 256'(wr_data_a), 256'(0));

    // 6b: wide configuration, write 0xBEEF to address 15
    n_pulse_b = 0;
    spi_frame(1'b1, {21'h1FBEEF, 11'h0}, 21, 1'b0, 1'b0);
    check("t6b_reg15", 256'(regs_b[255:240]), 256'(16'hBEEF));
    check("t6b_other_regs", 256'(regs_b[239:0]), 256'(0));
    check("t6b_wr_addr", 256'(wr_addr_b), 256'(4'hF));
    check("t6b_wr_data", 256'(wr_data_b), 256'(16'hBEEF));
    check("t6b_pulses", 256'(n_pulse_b), 256'(1));

    check("sb_writes_left", 256'(sb_q.size()), 256'(0));
    check("sb_cipo_left", 256'(cipo_q.size()), 256'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
